fft_magnitude_stream: RTL and testbench
=======================================

# fft_magnitude_stream

Converts the complex bin stream from the FFT core into the unsigned magnitude stream consumed by the signal metrics block: `magnitude_in`, `magnitude_valid`, `magnitude_last` and `magnitude_index`. It is the producer end of that interface. The block sits between the FFT output and the THD/fundamental search logic. It is a 3-stage pipeline with an alpha-max-plus-beta-min magnitude estimate, a bin index counter, framing checks and a frame counter. It has no backpressure and accepts one bin per cycle.

## Interface
- `IN_WIDTH`, 16, signed width of the FFT real and imaginary parts.
- `FFT_POINTS`, 1024, bins per frame; must be a power of two, ≥4.
- `MAG_WIDTH`, 24, output magnitude width; must be ≥ IN_WIDTH+1.

- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `fft_re` input IN_WIDTH: signed real part.
- `fft_im` input IN_WIDTH: signed imaginary part.
- `fft_valid` input 1: bin present this cycle.
- `fft_last` input 1: final bin of the frame; qualified by `fft_valid`.
- `magnitude_out` output MAG_WIDTH: magnitude estimate, zero-extended.
- `magnitude_valid` output 1: output beat valid.
- `magnitude_last` output 1: final output beat of the frame.
- `magnitude_index` output $clog2(FFT_POINTS): bin index of the output beat.
- `frame_count` output 16: number of completed output frames; wraps at 65535→0.
- `framing_error` output 1: one-cycle pulse on a framing violation.

## Operation
- Input counter `in_idx` advances by 1 on each `fft_valid` beat. It returns to 0 after a beat carrying `fft_last`, or after a beat at `in_idx == FFT_POINTS-1`.
- Stage 1 computes `|re|` and `|im|` as IN_WIDTH-bit unsigned values. An input of -2^(IN_WIDTH-1) gives 2^(IN_WIDTH-1) exactly, with no saturation. Stage 1 also captures the index, the end flag and the error flag.
- Stage 2 computes `mx = max(|re|,|im|)` and `mn = min(|re|,|im|)`.
- Stage 3 computes `mag = mx + (mn>>2) + (mn>>3)` (alpha=1, beta=3/8), truncating each shift.
  - The result fits in IN_WIDTH+1 bits and is zero-extended to MAG_WIDTH.
- The end of frame ("end") is `fft_last` OR `in_idx == FFT_POINTS-1`. `magnitude_last` is driven by end, so the consumer always sees a frame terminator.
- A framing error is raised in either case:
  - `fft_last` arrives while `in_idx != FFT_POINTS-1` (short frame).
  - `in_idx == FFT_POINTS-1` arrives without `fft_last` (missing last; the last is forced).
- `framing_error` pulses aligned with the offending beat's output cycle.
- `frame_count` increments in the cycle a beat with `magnitude_last` is emitted.
- `fft_valid` low inserts a bubble. The pipeline always advances and valid bits propagate per stage.

## Timing
- Latency is 3 cycles: an input beat at edge N produces an output beat registered at edge N+3.
- Sustained throughput is 1 bin per cycle. Gaps in the input are reproduced exactly at the output.
- All outputs are registered.
- Reset values: `magnitude_out`=0, `magnitude_valid`=0, `magnitude_last`=0, `magnitude_index`=0, `frame_count`=0, `framing_error`=0. Pipeline valids and `in_idx` also reset to 0.
- Reset mid-frame: in-flight beats are discarded and no partial `magnitude_last` is emitted. The first beat after reset is treated as index 0.
- Back-to-back frames: a beat following an end beat in the next cycle is index 0, with no dead cycle.
- `fft_last` asserted without `fft_valid` is ignored.

## Configuration
- `FFTMAG_HALF_ONLY_EN` defined:
  - Output beats for bins with index ≥ FFT_POINTS/2 are suppressed (`magnitude_valid` stays 0).
  - `magnitude_last` is asserted on bin FFT_POINTS/2-1, and `frame_count` counts those beats.
  - The input counter and the framing checks still cover the full frame.
  - `framing_error` still pulses 3 cycles after an offending beat, even if that beat is suppressed.
  - A short frame ending before bin FFT_POINTS/2-1 forces `magnitude_last` on its final beat.
- `FFTMAG_HALF_ONLY_EN` undefined: all FFT_POINTS bins are emitted, as described above.

## Test plan
- Single bin, re=3000, im=-4000 -> 3 cycles later `magnitude_out`=4000+750+375=5125, `magnitude_index`=0.
- Extreme input, re=-32768, im=-32768 -> `magnitude_out`=32768+8192+4096=45056, with no wrap.
- Full 1024-bin frame streamed continuously with `fft_last` on bin 1023:
  - indices 0..1023 in order, `magnitude_last` only on 1023, `frame_count`=1, no `framing_error`.
  - An immediately following frame starts at index 0.
- Short frame with `fft_last` on bin 9 -> `magnitude_last` and `framing_error` on index 9. The next beat is index 0.
- Missing last, 1030 beats without `fft_last`:
  - `magnitude_last` is forced on index 1023 with a `framing_error` pulse.
  - Beats 1024..1029 emerge as indices 0..5.
- Reset asserted at bin 500, then a new frame -> outputs go to 0 immediately, no stale beats appear, and the first output is index 0 with `frame_count` 0.
- With `FFTMAG_HALF_ONLY_EN` defined, a full frame produces 512 valid beats, last on 511, and nothing for 512..1023.

Source files
------------

// File: rtl/fft_magnitude_stream_if.sv
// FFT bin stream in, magnitude stream out. The DUT takes the master modport (consumes bins,
// produces magnitudes); the slave modport is the opposite side.
interface fft_magnitude_stream_if #(
    parameter int IN_WIDTH   = 16,
    parameter int FFT_POINTS = 1024,
    parameter int MAG_WIDTH  = 24
);
    localparam int IDX_WIDTH = $clog2(FFT_POINTS);

    logic signed [IN_WIDTH-1:0]  fft_re;
    logic signed [IN_WIDTH-1:0]  fft_im;
    logic                        fft_valid;
    logic                        fft_last;
    logic        [MAG_WIDTH-1:0] magnitude_out;
    logic                        magnitude_valid;
    logic                        magnitude_last;
    logic        [IDX_WIDTH-1:0] magnitude_index;
    logic        [15:0]          frame_count;
    logic                        framing_error;

    modport master (
        input  fft_re, fft_im, fft_valid, fft_last,
        output magnitude_out, magnitude_valid, magnitude_last, magnitude_index,
        output frame_count, framing_error
    );

    modport slave (
        output fft_re, fft_im, fft_valid, fft_last,
        input  magnitude_out, magnitude_valid, magnitude_last, magnitude_index,
        input  frame_count, framing_error
    );
endinterface

// File: rtl/fft_magnitude_stream.sv
// Three-stage alpha-max-plus-beta-min magnitude (alpha=1, beta=3/8) with bin indexing, framing
// checks and a frame counter. FFTMAG_HALF_ONLY_EN emits only the lower half of each frame.
module fft_magnitude_stream #(
    parameter int IN_WIDTH   = 16,
    parameter int FFT_POINTS = 1024,
    parameter int MAG_WIDTH  = 24
) (
    input logic                    clk,
    input logic                    rst,
    fft_magnitude_stream_if.master bus
);
    localparam int IDX_WIDTH = $clog2(FFT_POINTS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FFT_POINTS - 1);
`ifdef FFTMAG_HALF_ONLY_EN
    localparam logic [IDX_WIDTH-1:0] HALF_LAST_IDX = IDX_WIDTH'(FFT_POINTS / 2 - 1);
`endif

    // Two's-complement abs in the same width: the most negative input maps to 2^(IN_WIDTH-1).
    function automatic logic [IN_WIDTH-1:0] abs_val(input logic signed [IN_WIDTH-1:0] x);
        return x[IN_WIDTH-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    logic [IDX_WIDTH-1:0] in_idx;
    logic                 at_top;
    logic                 beat_end;
    logic                 beat_err;

    assign at_top   = (in_idx == LAST_IDX);
    assign beat_end = bus.fft_last | at_top;
    assign beat_err = bus.fft_last ^ at_top;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_idx <= '0;
        end else if (bus.fft_valid) begin
            in_idx <= beat_end ? '0 : in_idx + 1'b1;
        end
    end

    logic                 s1_valid, s1_end, s1_err;
    logic [IN_WIDTH-1:0]  s1_re_abs, s1_im_abs;
    logic [IDX_WIDTH-1:0] s1_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_end    <= 1'b0;
            s1_err    <= 1'b0;
            s1_re_abs <= '0;
            s1_im_abs <= '0;
            s1_idx    <= '0;
        end else begin
            s1_valid <= bus.fft_valid;
            if (bus.fft_valid) begin
                s1_end    <= beat_end;
                s1_err    <= beat_err;
                s1_re_abs <= abs_val(bus.fft_re);
                s1_im_abs <= abs_val(bus.fft_im);
                s1_idx    <= in_idx;
            end
        end
    end

    logic                 s2_valid, s2_end, s2_err;
    logic [IN_WIDTH-1:0]  s2_mx, s2_mn;
    logic [IDX_WIDTH-1:0] s2_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_end   <= 1'b0;
            s2_err   <= 1'b0;
            s2_mx    <= '0;
            s2_mn    <= '0;
            s2_idx   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_end <= s1_end;
                s2_err <= s1_err;
                s2_mx  <= (s1_re_abs >= s1_im_abs) ? s1_re_abs : s1_im_abs;
                s2_mn  <= (s1_re_abs >= s1_im_abs) ? s1_im_abs : s1_re_abs;
                s2_idx <= s1_idx;
            end
        end
    end

    // mx + 3/8*mn stays below 2^IN_WIDTH, so one extra bit suffices.
    logic [IN_WIDTH:0] mag;
    logic              emit;
    logic              emit_last;

    assign mag = {1'b0, s2_mx} + (IN_WIDTH + 1)'(s2_mn >> 2) + (IN_WIDTH + 1)'(s2_mn >> 3);

`ifdef FFTMAG_HALF_ONLY_EN
    assign emit      = s2_valid & ~s2_idx[IDX_WIDTH-1];
    assign emit_last = emit & (s2_end | (s2_idx == HALF_LAST_IDX));
`else
    assign emit      = s2_valid;
    assign emit_last = s2_valid & s2_end;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.magnitude_out   <= '0;
            bus.magnitude_valid <= 1'b0;
            bus.magnitude_last  <= 1'b0;
            bus.magnitude_index <= '0;
            bus.frame_count     <= '0;
            bus.framing_error   <= 1'b0;
        end else begin
            bus.magnitude_valid <= emit;
            bus.magnitude_last  <= emit_last;
            // Error pulses even for beats suppressed in half-only mode.
            bus.framing_error   <= s2_valid & s2_err;
            bus.frame_count     <= bus.frame_count + 16'(emit_last);
            if (emit) begin
                bus.magnitude_out   <= MAG_WIDTH'(mag);
                bus.magnitude_index <= s2_idx;
            end
        end
    end
endmodule

// File: tb/tb_fft_magnitude_stream.sv
// Directed bench for fft_magnitude_stream: vector table plus framing/reset sequences.
// Honours FFTMAG_HALF_ONLY_EN in its expected-beat model.
module tb_fft_magnitude_stream;
    localparam int IN_W  = 16;
    localparam int N     = 1024;
    localparam int MAG_W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_magnitude_stream_if #(.IN_WIDTH(IN_W), .FFT_POINTS(N), .MAG_WIDTH(MAG_W)) bus ();

    fft_magnitude_stream #(.IN_WIDTH(IN_W), .FFT_POINTS(N), .MAG_WIDTH(MAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int re; int im; int mag; int idx; } vec_t;
    typedef struct { int mag; int idx; bit last; bit err; } exp_t;

    vec_t vecs[10];
    exp_t exp_q[$];
    exp_t exp_e;

    int vectors = 0, miscompares = 0;
    int tb_idx = 0, exp_frames = 0, exp_err_total = 0;
    int bad_beats = 0, err_seen = 0, beats_seen = 0;
    int beats_before;

    function automatic int mag_of(input int re, input int im);
        int ar, ai, mx, mn;
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        mx = (ar > ai) ? ar : ai;
        mn = (ar > ai) ? ai : ar;
        return mx + mn / 4 + mn / 8;
    endfunction

    function automatic int dre(input int i);
        return ((i * 73) % 4001) - 2000;
    endfunction

    function automatic int dim(input int i);
        return 2000 - ((i * 131) % 3001) * 10;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One valid beat; the model queues what should emerge three cycles later.
    task automatic beat(input int re, input int im, input bit last);
        bit top, endf, err, emit, elast;
        bus.fft_valid = 1'b1;
        bus.fft_last  = last;
        bus.fft_re    = re[IN_W-1:0];
        bus.fft_im    = im[IN_W-1:0];
        top  = (tb_idx == N - 1);
        endf = last || top;
        err  = (last != top);
`ifdef FFTMAG_HALF_ONLY_EN
        emit  = (tb_idx < N / 2);
        elast = endf || (tb_idx == N / 2 - 1);
`else
        emit  = 1'b1;
        elast = endf;
`endif
        if (emit) exp_q.push_back('{mag_of(re, im), tb_idx, elast, err});
        if (emit && elast) exp_frames = (exp_frames + 1) % 65536;
        if (err) exp_err_total++;
        tb_idx = endf ? 0 : tb_idx + 1;
        @(posedge clk);
        #1;
        bus.fft_valid = 1'b0;
        bus.fft_last  = 1'b0;
    endtask

    task automatic idle(input int n, input bit last);
        bus.fft_valid = 1'b0;
        bus.fft_last  = last;
        repeat (n) @(posedge clk);
        #1;
        bus.fft_last = 1'b0;
    endtask

    task automatic drain_and_check(input string tag);
        idle(6, 1'b0);
        check({tag, " bad beats"}, bad_beats, 0);
        check({tag, " pending beats"}, exp_q.size(), 0);
        check({tag, " framing_error pulses"}, err_seen, exp_err_total);
        check({tag, " frame_count"}, bus.frame_count, exp_frames);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.framing_error) err_seen++;
            if (bus.magnitude_valid) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    bad_beats++;
                end else begin
                    exp_e = exp_q.pop_front();
                    if (int'(bus.magnitude_out) != exp_e.mag || int'(bus.magnitude_index) != exp_e.idx
                        || bus.magnitude_last != exp_e.last || bus.framing_error != exp_e.err)
                        bad_beats++;
                end
            end
        end
    end

    initial begin
        vecs[0] = '{3000, -4000, 5125, 0};
        vecs[1] = '{-32768, -32768, 45056, 1};
        vecs[2] = '{0, 0, 0, 2};
        vecs[3] = '{100, 0, 100, 3};
        vecs[4] = '{0, -1, 1, 4};
        vecs[5] = '{32767, 32767, 45053, 5};
        vecs[6] = '{-8, 16, 19, 6};
        vecs[7] = '{7, 7, 8, 7};
        vecs[8] = '{-32768, 1, 32768, 8};
        vecs[9] = '{1000, -2000, 2375, 9};

        bus.fft_valid = 1'b0;
        bus.fft_last  = 1'b0;
        bus.fft_re    = '0;
        bus.fft_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset magnitude_valid", bus.magnitude_valid, 0);
        check("reset magnitude_out", bus.magnitude_out, 0);
        check("reset magnitude_last", bus.magnitude_last, 0);
        check("reset magnitude_index", bus.magnitude_index, 0);
        check("reset frame_count", bus.frame_count, 0);
        check("reset framing_error", bus.framing_error, 0);
        rst = 1'b0;
        idle(2, 1'b0);

        // Table: isolated beats, output must appear exactly three cycles after presentation.
        for (int i = 0; i < 10; i++) begin
            beat(vecs[i].re, vecs[i].im, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d early valid", i), bus.magnitude_valid, 0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid", i), bus.magnitude_valid, 1);
            check($sformatf("vec%0d magnitude", i), bus.magnitude_out, vecs[i].mag);
            check($sformatf("vec%0d index", i), bus.magnitude_index, vecs[i].idx);
        end
        beat(5, 5, 1'b1);
        drain_and_check("table");

        // Full frame, back-to-back short frame (ignored unqualified last), then missing last.
        for (int i = 0; i < N; i++) beat(dre(i), dim(i), i == N - 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) idle(1, 1'b1);
            beat(dre(i + 7), dim(i + 3), i == 9);
        end
        for (int i = 0; i < 1030; i++) beat(dre(i + 11), dim(i), 1'b0);
        drain_and_check("frames");
        check("frame_count after framing tests", bus.frame_count, 4);
        check("framing_error total after framing tests", err_seen, 3);

        // Reset mid-frame with beats in flight.
        while (tb_idx != 500) beat(dre(tb_idx), dim(tb_idx), 1'b0);
        beat(123, 456, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        tb_idx     = 0;
        exp_frames = 0;
        #1;
        check("midreset magnitude_valid", bus.magnitude_valid, 0);
        check("midreset magnitude_out", bus.magnitude_out, 0);
        check("midreset magnitude_last", bus.magnitude_last, 0);
        check("midreset magnitude_index", bus.magnitude_index, 0);
        check("midreset frame_count", bus.frame_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5, 1'b0);
        check("post-reset stale beats", bad_beats, 0);

        beats_before = beats_seen;
        beat(11, -22, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("post-reset first valid", bus.magnitude_valid, 1);
        check("post-reset first index", bus.magnitude_index, 0);
        check("post-reset first magnitude", bus.magnitude_out, 25);
        check("post-reset first frame_count", bus.frame_count, 0);
        for (int i = 1; i < N; i++) beat(dim(i), dre(i), i == N - 1);
        drain_and_check("post-reset frame");
`ifdef FFTMAG_HALF_ONLY_EN
        check("post-reset frame beat count", beats_seen - beats_before, N / 2);
`else
        check("post-reset frame beat count", beats_seen - beats_before, N);
`endif
        check("post-reset frame_count", bus.frame_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
